tof_shot_accum: RTL
===================

Name: tof_shot_accum

Overview:
- Downstream consumer of the free-running fine/coarse timestamp counter in the rangefinder.
- Samples the combined timestamp on each start (laser fire) and stop (echo) pulse, and computes the modular time-of-flight per shot.
- Applies echo blanking and a timeout, then accumulates 2^LOG2_AVG shots.
- Presents one averaged result to the readout stage over a valid/ready handshake.

Parameters:
- TS_W, 21, timestamp width = coarse (8) + fine (13); fixed by the counter stage.
- LOG2_AVG, 3, log2 of shots per result (N = 8).
- BLANK, 16, stops with elapsed < BLANK ticks are ignored (optical crosstalk).
- TIMEOUT, 100000, elapsed >= TIMEOUT with no valid stop makes the shot a miss. Must be < 2^TS_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle laser-fire pulse
- stop  in  1  single-cycle echo pulse
- fine_cnt  in  13  fine count from the timestamp counter
- coarse_cnt  in  8  coarse count from the timestamp counter
- busy  out  1  high when state != IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_sum  out  TS_W+LOG2_AVG  sum of hit TOFs
- res_hits  out  LOG2_AVG+1  number of hits in the batch
- res_miss  out  LOG2_AVG+1  number of misses = N - res_hits
- res_avg  out  TS_W  res_sum >> LOG2_AVG when res_hits == N, else 0

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset mid-operation goes to IDLE next cycle.
- Reset values: all outputs 0; start_ts, sum, hit and shot counters 0.
- Timestamp: ts = {coarse_cnt, fine_cnt}, sampled in the same cycle as start or stop.
- Elapsed time: elapsed = (ts - start_ts) mod 2^TS_W, so counter wrap-around is handled transparently.
- States: IDLE, RUN, OUT.
- IDLE:
  - start -> start_ts <= ts, go to RUN.
  - stop is ignored.
- RUN: events are evaluated in priority order each cycle:
  1. stop && elapsed >= BLANK -> hit: sum += elapsed, hits++, shot++. A start in the same cycle is ignored.
  2. elapsed >= TIMEOUT -> miss: shot++.
  3. start (no qualifying stop) -> miss for the current shot, shot++, start_ts <= ts, stay in RUN unless the batch is complete.
  4. stop && elapsed < BLANK -> ignored, stay in RUN.
- Shot completion:
  - If shot == N, latch res_* and go to OUT.
  - Otherwise go to IDLE. For rule 3, stay in RUN with the new start_ts.
- Result latency: res_valid rises 1 cycle after the terminating event of the Nth shot.
- OUT:
  - res_valid = 1; res_* are held stable until the handshake.
  - start and stop are ignored while in OUT.
  - res_valid && res_ready -> clear sum and counters, go to IDLE. res_valid drops the next cycle.
  - res_ready has no effect while res_valid = 0.
- Width rules:
  - sum is TS_W+LOG2_AVG bits and cannot overflow, since each term is < 2^TS_W.
  - Counters are LOG2_AVG+1 bits.

Decomposition:
- Package tof_pkg: TS_W, state enum (IDLE/RUN/OUT), and a function for the modular timestamp difference.
- Sub-module tof_delta: combinational elapsed computation plus the blank and timeout compares. Outputs: elapsed, blanked, timed_out.
- The top level holds the FSM, accumulators and output registers.

Test Plan (bench uses LOG2_AVG=2 (N=4), BLANK=16, TIMEOUT=1000):
- 4 shots, stop at elapsed 200 each -> res_valid, res_sum=800, res_hits=4, res_miss=0, res_avg=200.
- Wrap-around: start at ts=21'h1FFFF0, stop at ts=21'h000020, plus 3 shots at 48 -> res_sum=192, res_avg=48.
- Blanking: stop at elapsed 10, then at 300; other shots at 300 -> every shot is a hit of 300, res_sum=1200, res_hits=4.
- Timeout: 4 starts with no stop -> each miss at elapsed exactly 1000. res_sum=0, res_hits=0, res_miss=4, res_avg=0. Also check a stop at elapsed 1000 together with the timeout -> counted as a hit.
- Backpressure: hold res_ready=0 for 10 cycles and pulse start/stop -> outputs stable, no state change. res_ready=1 -> IDLE and busy=0 next cycle.
- Reset mid-RUN after 2 hits -> busy=0 next cycle. A following 4-shot batch at 100 gives res_sum=400, with no residue from the first batch.

Source files
------------

// File: rtl/tof_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tof_pkg
// Description : Shared timestamp width, FSM state type and modular timestamp
//               difference helper for the time-of-flight shot accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package tof_pkg;

    // Combined timestamp = {coarse, fine}; widths fixed by the counter stage.
    localparam int COARSE_W = 8;
    localparam int FINE_W   = 13;
    localparam int TS_W     = COARSE_W + FINE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Unsigned subtraction truncated to TS_W bits gives the elapsed time
    // modulo 2^TS_W, so a counter wrap between start and stop is transparent.
    function automatic logic [TS_W-1:0] ts_diff(input logic [TS_W-1:0] ts_now,
                                                input logic [TS_W-1:0] ts_ref);
        return ts_now - ts_ref;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tof_delta.sv
`default_nettype none
// ============================================================================
// Module      : tof_delta
// Description : Combinational elapsed-time computation with echo-blanking and
//               timeout compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tof_delta
    import tof_pkg::*;
#(
    parameter int BLANK   = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic [TS_W-1:0] i_ts,
    input  logic [TS_W-1:0] i_start_ts,
    output logic [TS_W-1:0] elapsed,
    output logic            blanked,
    output logic            timed_out
);

    localparam logic [TS_W-1:0] c_BLANK   = TS_W'(BLANK);
    localparam logic [TS_W-1:0] c_TIMEOUT = TS_W'(TIMEOUT);

    // Elapsed ticks since the last start, plus the two qualifying compares.
    always_comb begin
        elapsed   = ts_diff(i_ts, i_start_ts);
        blanked   = (elapsed < c_BLANK);
        timed_out = (elapsed >= c_TIMEOUT);
    end

endmodule
`default_nettype wire

// File: rtl/tof_shot_accum.sv
`default_nettype none
// ============================================================================
// Module      : tof_shot_accum
// Description : Samples start/stop timestamps, measures per-shot time of
//               flight with blanking and timeout, accumulates 2^LOG2_AVG
//               shots and presents the batch result over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tof_shot_accum
    import tof_pkg::*;
#(
    parameter int LOG2_AVG = 3,
    parameter int BLANK    = 16,
    parameter int TIMEOUT  = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [FINE_W-1:0]        fine_cnt,
    input  logic [COARSE_W-1:0]      coarse_cnt,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [TS_W+LOG2_AVG-1:0] res_sum,
    output logic [LOG2_AVG:0]        res_hits,
    output logic [LOG2_AVG:0]        res_miss,
    output logic [TS_W-1:0]          res_avg
);

    localparam int SUM_W = TS_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0] c_N   = CNT_W'(1 << LOG2_AVG);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    state_t             r_state,    w_state;
    logic [TS_W-1:0]    r_start_ts, w_start_ts;
    logic [SUM_W-1:0]   r_sum,      w_sum;
    logic [CNT_W-1:0]   r_hits,     w_hits;
    logic [CNT_W-1:0]   r_shots,    w_shots;
    logic               r_res_valid, w_res_valid;
    logic [SUM_W-1:0]   r_res_sum,  w_res_sum;
    logic [CNT_W-1:0]   r_res_hits, w_res_hits;
    logic [CNT_W-1:0]   r_res_miss, w_res_miss;
    logic [TS_W-1:0]    r_res_avg,  w_res_avg;

    logic [TS_W-1:0]    w_ts;
    logic [TS_W-1:0]    w_elapsed;
    logic               w_blanked;
    logic               w_timed_out;
    logic               w_shot_end;
    logic               w_restart;

    assign w_ts = {coarse_cnt, fine_cnt};

    tof_delta #(
        .BLANK   (BLANK),
        .TIMEOUT (TIMEOUT)
    ) u_delta (
        .i_ts       (w_ts),
        .i_start_ts (r_start_ts),
        .elapsed    (w_elapsed),
        .blanked    (w_blanked),
        .timed_out  (w_timed_out)
    );

    // Next-state, accumulator and result-latch logic; everything holds by default.
    always_comb begin
        w_state     = r_state;
        w_start_ts  = r_start_ts;
        w_sum       = r_sum;
        w_hits      = r_hits;
        w_shots     = r_shots;
        w_res_valid = r_res_valid;
        w_res_sum   = r_res_sum;
        w_res_hits  = r_res_hits;
        w_res_miss  = r_res_miss;
        w_res_avg   = r_res_avg;
        w_shot_end  = 1'b0;
        w_restart   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_ts = w_ts;
                    w_state    = ST_RUN;
                end
            end

            ST_RUN: begin
                // Qualifying stop wins over timeout, which wins over re-fire.
                if (stop && !w_blanked) begin
                    w_sum      = r_sum + SUM_W'(w_elapsed);
                    w_hits     = r_hits + c_ONE;
                    w_shot_end = 1'b1;
                end else if (w_timed_out) begin
                    w_shot_end = 1'b1;
                end else if (start) begin
                    w_shot_end = 1'b1;
                    w_restart  = 1'b1;
                end

                if (w_shot_end) begin
                    w_shots = r_shots + c_ONE;
                    if (w_shots == c_N) begin
                        w_res_valid = 1'b1;
                        w_res_sum   = w_sum;
                        w_res_hits  = w_hits;
                        w_res_miss  = c_N - w_hits;
                        w_res_avg   = (w_hits == c_N) ? w_sum[SUM_W-1:LOG2_AVG] : '0;
                        w_state     = ST_OUT;
                    end else if (w_restart) begin
                        // A re-fire closes the old shot and opens the next one.
                        w_start_ts = w_ts;
                        w_state    = ST_RUN;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end

            ST_OUT: begin
                if (res_ready) begin
                    w_res_valid = 1'b0;
                    w_sum       = '0;
                    w_hits      = '0;
                    w_shots     = '0;
                    w_state     = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, accumulator and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_start_ts  <= '0;
            r_sum       <= '0;
            r_hits      <= '0;
            r_shots     <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_hits  <= '0;
            r_res_miss  <= '0;
            r_res_avg   <= '0;
        end else begin
            r_state     <= w_state;
            r_start_ts  <= w_start_ts;
            r_sum       <= w_sum;
            r_hits      <= w_hits;
            r_shots     <= w_shots;
            r_res_valid <= w_res_valid;
            r_res_sum   <= w_res_sum;
            r_res_hits  <= w_res_hits;
            r_res_miss  <= w_res_miss;
            r_res_avg   <= w_res_avg;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_hits  = r_res_hits;
    assign res_miss  = r_res_miss;
    assign res_avg   = r_res_avg;

endmodule
`default_nettype wire
